// File: rtl/exhaustive_vector_sequencer.sv
// Exhaustive vector sequencer: sweeps every CUT input pattern in ascending
// order, holds each one for SETTLE_CYCLES, then captures the CUT response
// into a readable memory and folds it into a 16-bit MISR signature.
module exhaustive_vector_sequencer #(
  parameter int IN_WIDTH      = 3,
  parameter int OUT_WIDTH     = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [IN_WIDTH-1:0]  vec_out,
  output logic                 vec_valid,
  input  logic [OUT_WIDTH-1:0] resp_in,
  output logic                 busy,
  output logic                 done,
  output logic [IN_WIDTH:0]    vec_count,
  output logic [15:0]          signature,
  input  logic [IN_WIDTH-1:0]  rsp_rd_addr,
  output logic [OUT_WIDTH-1:0] rsp_rd_data
);

  localparam int NUM_VEC = 2**IN_WIDTH;
  localparam int CW      = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   vec_q, vec_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IN_WIDTH:0]     count_q, count_d;
  logic [15:0]           sig_q, sig_d;
  logic [OUT_WIDTH-1:0]  mem_q [NUM_VEC];
  logic [OUT_WIDTH-1:0]  mem_d [NUM_VEC];
  logic [15:0]           resp_ext;
  logic                  fb;

  // Next-state: start handling, settle counting and response capture.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    sig_d    = sig_q;
    mem_d    = mem_q;
    resp_ext = '0;
    resp_ext[OUT_WIDTH-1:0] = resp_in;
    fb       = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          cnt_d   = '0;
          count_d = '0;
          sig_d   = 16'hFFFF;
        end
      end
      S_DRIVE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          mem_d[vec_q] = resp_in;
          sig_d        = {sig_q[14:0], fb} ^ resp_ext;
          count_d      = count_q + (IN_WIDTH+1)'(1);
          cnt_d        = '0;
          if (vec_q == '1) state_d = S_DONE;
          else             vec_d   = vec_q + IN_WIDTH'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      sig_q   <= 16'hFFFF;
      for (int unsigned i = 0; i < NUM_VEC; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      sig_q   <= sig_d;
      mem_q   <= mem_d;
    end
  end

  assign vec_out     = vec_q;
  assign vec_valid   = (state_q == S_DRIVE);
  assign busy        = (state_q == S_DRIVE);
  assign done        = (state_q == S_DONE);
  assign vec_count   = count_q;
  assign signature   = sig_q;
  assign rsp_rd_data = mem_q[rsp_rd_addr];

endmodule

// File: doc/exhaustive_vector_sequencer.md
Name: exhaustive_vector_sequencer

Overview:
Sequential stimulus/response stage that sits directly upstream and downstream of a small combinational circuit-under-test (CUT). It drives every input pattern 0..2^IN_WIDTH-1 in ascending order onto the CUT, waits a programmable settle time, and samples the CUT outputs. Each response is stored in a readable response memory and folded into a 16-bit MISR signature. It replaces free-running testbench loops with a synthesizable, restartable sweep.

Parameters:
IN_WIDTH, 3, CUT input width; sweep covers NUM_VEC = 2**IN_WIDTH vectors (derived localparam).
OUT_WIDTH, 2, CUT output width; must be ≤ 16.
SETTLE_CYCLES, 4, clock cycles each vector is held; must be ≥ 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE or DONE
vec_out  output  IN_WIDTH  vector driven to the CUT inputs, MSB first ({A,B,C} for width 3)
vec_valid  output  1  high while vec_out is being applied (DRIVE state)
resp_in  input  OUT_WIDTH  CUT outputs ({D,E} for width 2)
busy  output  1  sweep in progress
done  output  1  level; sweep completed; cleared by the next accepted start or by reset
vec_count  output  IN_WIDTH+1  number of responses captured in the current/last sweep
signature  output  16  MISR value
rsp_rd_addr  input  IN_WIDTH  response memory read address
rsp_rd_data  output  OUT_WIDTH  combinational read of mem[rsp_rd_addr]

Behaviour:
- Reset (async, rst_n=0): state=IDLE; vec_out=0, vec_valid=0, busy=0, done=0, vec_count=0, signature=16'hFFFF, settle counter=0, all response memory entries=0. Reset takes effect immediately, including mid-sweep; the sweep is abandoned and is not resumed.
- FSM states: IDLE, DRIVE, DONE.
- IDLE/DONE with start=1 at edge E0 -> DRIVE. At the same edge: vec_out=0, settle counter=0, vec_count=0, signature=16'hFFFF, done=0. busy=1 and vec_valid=1 follow from the DRIVE state.
- DRIVE: the settle counter increments each cycle. On the edge where counter==SETTLE_CYCLES-1, the block performs all of the following in one edge:
  - mem[vec_out] <= resp_in
  - signature <= {sig[14:0], fb} ^ zero-extended resp_in, where fb = sig[15]^sig[14]^sig[12]^sig[3]
  - vec_count += 1
  - settle counter reset to 0
  - if vec_out == NUM_VEC-1, go to DONE (vec_out holds its value); otherwise vec_out += 1.
- Timing: each vector is held exactly SETTLE_CYCLES cycles. Vector k is captured at edge E0 + SETTLE_CYCLES*(k+1). The last capture is at E0 + NUM_VEC*SETTLE_CYCLES; DONE is entered at that edge.
- DONE: busy=0, vec_valid=0, done=1. vec_count, signature and memory remain stable until the next start or reset.
- start while in DRIVE: ignored, with no restart and no side effects.
- start held high continuously: a new sweep begins on the first edge in DONE, and done pulses high for exactly one cycle.
- The memory read port is always valid. Reading while in DRIVE returns either the old or the new data for the address being written, with no glitch requirement beyond the settled value.
- vec_count saturates naturally at NUM_VEC; its IN_WIDTH+1 width prevents wrap-around.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, start=0 -> all outputs at reset values; signature=16'hFFFF; every memory address reads 0.
- Full sweep with defaults, resp_in = {^vec_out, &vec_out}, start pulsed for 1 cycle:
  - vec_out steps 0..7, each held 4 cycles; busy high for 32 cycles.
  - done rises at edge E0+32; vec_count=8.
  - mem reads 0,2,2,0,2,0,0,3 for addresses 0..7.
  - signature equals the bench golden MISR model.
- Settle sampling: resp_in driven X/garbage for the first 3 cycles of each vector and correct on the 4th -> memory holds only the correct values.
- start asserted mid-sweep (at vector 3) -> no restart; sweep completes at E0+32 with vec_count=8.
- rst_n pulsed low during vector 5 -> busy, vec_valid and vec_out go to 0 immediately (async); memory is cleared; a subsequent start yields a full, correct sweep.
- SETTLE_CYCLES=1 build with start held high -> one vector captured per cycle; done high for 1 cycle every 9 cycles; back-to-back sweeps produce identical signatures.
